// File: rtl/ldpc_ber_block_stats.sv
// BER and per-block error statistics on the decoder output stream (all-zero codeword assumed).
// Optional max per-block error tracking is built when LDPC_BER_MAX_ERR_EN is defined.
module ldpc_ber_block_stats #(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned BLK_CNT_WIDTH = 64,
    parameter int unsigned ACC_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic [DATA_WIDTH-1:0]    last_mask,
    input  logic [ACC_WIDTH-1:0]     err_threshold,
    input  logic [DATA_WIDTH-1:0]    s_axis_dout_tdata,
    input  logic                     s_axis_dout_tvalid,
    output logic                     s_axis_dout_tready,
    input  logic                     s_axis_dout_tlast,
    output logic [CNT_WIDTH-1:0]     bit_errors,
    output logic [CNT_WIDTH-1:0]     block_errors,
    output logic [BLK_CNT_WIDTH-1:0] blocks_done,
    output logic                     saturated,
    output logic [ACC_WIDTH-1:0]     max_block_err
);

    localparam int unsigned LANES     = DATA_WIDTH / 16;
    localparam int unsigned BEAT_W    = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned ACC_SUM_W = ((ACC_WIDTH > BEAT_W) ? ACC_WIDTH : BEAT_W) + 1;
    localparam int unsigned CNT_SUM_W = ((CNT_WIDTH > BEAT_W) ? CNT_WIDTH : BEAT_W) + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    logic ready_q;
    logic accept;
    logic [DATA_WIDTH-1:0] masked;

    logic [LANES-1:0][4:0] lane_cnt_d, lane_cnt_q;
    logic                  s1_valid_q, s1_last_q;

    logic [BEAT_W-1:0] beat_err_d, beat_err_q;
    logic              s2_valid_q, s2_last_q;

    logic [ACC_WIDTH-1:0]     blk_acc_d, blk_acc_q;
    logic [CNT_WIDTH-1:0]     bit_errors_d, bit_errors_q;
    logic [CNT_WIDTH-1:0]     block_errors_d, block_errors_q;
    logic [BLK_CNT_WIDTH-1:0] blocks_done_d, blocks_done_q;
    logic                     saturated_d, saturated_q;

    logic [ACC_SUM_W-1:0] acc_wide;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [CNT_SUM_W-1:0] bits_wide;

    // Clear wins over a coincident beat even though tready is still high that cycle.
    assign accept = s_axis_dout_tvalid & ready_q & ~clear;
    assign masked = s_axis_dout_tdata & (s_axis_dout_tlast ? last_mask : {DATA_WIDTH{1'b1}});

    always_comb begin
        lane_cnt_d = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_cnt_d[l] = popcnt16(masked[l*16 +: 16]);
        end
    end

    always_comb begin
        beat_err_d = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_err_d = beat_err_d + BEAT_W'(lane_cnt_q[l]);
        end
    end

    always_comb begin
        acc_wide  = ACC_SUM_W'(blk_acc_q) + ACC_SUM_W'(beat_err_q);
        acc_sum   = (acc_wide > ACC_SUM_W'(ACC_MAX)) ? ACC_MAX : acc_wide[ACC_WIDTH-1:0];
        bits_wide = CNT_SUM_W'(bit_errors_q) + CNT_SUM_W'(beat_err_q);

        blk_acc_d      = blk_acc_q;
        bit_errors_d   = bit_errors_q;
        block_errors_d = block_errors_q;
        blocks_done_d  = blocks_done_q;
        saturated_d    = saturated_q;

        if (s2_valid_q) begin
            bit_errors_d = (bits_wide > CNT_SUM_W'(CNT_MAX)) ? CNT_MAX
                                                              : bits_wide[CNT_WIDTH-1:0];
            if (s2_last_q) begin
                blk_acc_d = '0;
                if (blocks_done_q != '1) begin
                    blocks_done_d = blocks_done_q + BLK_CNT_WIDTH'(1);
                end
                if ((acc_sum > err_threshold) && (block_errors_q != '1)) begin
                    block_errors_d = block_errors_q + CNT_WIDTH'(1);
                end
            end else begin
                blk_acc_d = acc_sum;
            end
            saturated_d = saturated_q | (acc_sum == ACC_MAX) | (bit_errors_d == CNT_MAX)
                        | (block_errors_d == CNT_MAX) | (blocks_done_d == '1);
        end
    end

    always_ff @(posedge clk) begin
        ready_q <= resetn & ~clear;
        if (!resetn || clear) begin
            lane_cnt_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            beat_err_q     <= '0;
            s2_valid_q     <= 1'b0;
            s2_last_q      <= 1'b0;
            blk_acc_q      <= '0;
            bit_errors_q   <= '0;
            block_errors_q <= '0;
            blocks_done_q  <= '0;
            saturated_q    <= 1'b0;
        end else begin
            lane_cnt_q     <= lane_cnt_d;
            s1_valid_q     <= accept;
            s1_last_q      <= s_axis_dout_tlast;
            beat_err_q     <= beat_err_d;
            s2_valid_q     <= s1_valid_q;
            s2_last_q      <= s1_last_q;
            blk_acc_q      <= blk_acc_d;
            bit_errors_q   <= bit_errors_d;
            block_errors_q <= block_errors_d;
            blocks_done_q  <= blocks_done_d;
            saturated_q    <= saturated_d;
        end
    end

`ifdef LDPC_BER_MAX_ERR_EN
    logic [ACC_WIDTH-1:0] max_err_d, max_err_q;

    always_comb begin
        max_err_d = max_err_q;
        if (s2_valid_q && s2_last_q && (acc_sum > max_err_q)) begin
            max_err_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            max_err_q <= '0;
        end else begin
            max_err_q <= max_err_d;
        end
    end

    assign max_block_err = max_err_q;
`else
    assign max_block_err = '0;
`endif

    assign s_axis_dout_tready = ready_q;
    assign bit_errors         = bit_errors_q;
    assign block_errors       = block_errors_q;
    assign blocks_done        = blocks_done_q;
    assign saturated          = saturated_q;

endmodule

// File: tb/tb_ldpc_ber_block_stats.sv
// Directed bench for ldpc_ber_block_stats: beats are queued as they are accepted and retired
// into a reference model when their results are due, with outputs compared every cycle.
module tb_ldpc_ber_block_stats;

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 8;
    localparam int unsigned BW = 64;
    localparam int unsigned AW = 16;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
    localparam int unsigned ACC_MAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear;
    logic [DW-1:0] last_mask;
    logic [AW-1:0] err_threshold;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [CW-1:0] bit_errors;
    logic [CW-1:0] block_errors;
    logic [BW-1:0] blocks_done;
    logic          saturated;
    logic [AW-1:0] max_block_err;

    ldpc_ber_block_stats #(
        .DATA_WIDTH   (DW),
        .CNT_WIDTH    (CW),
        .BLK_CNT_WIDTH(BW),
        .ACC_WIDTH    (AW)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .clear             (clear),
        .last_mask         (last_mask),
        .err_threshold     (err_threshold),
        .s_axis_dout_tdata (tdata),
        .s_axis_dout_tvalid(tvalid),
        .s_axis_dout_tready(tready),
        .s_axis_dout_tlast (tlast),
        .bit_errors        (bit_errors),
        .block_errors      (block_errors),
        .blocks_done       (blocks_done),
        .saturated         (saturated),
        .max_block_err     (max_block_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        int unsigned err;
        bit          last;
    } ent_t;

    ent_t        sb[$];
    int unsigned cyc;
    int unsigned n_tests;
    int unsigned n_fail;
    bit          exp_ready;
    int unsigned m_bits, m_blkerr, m_acc, m_max;
    longint unsigned m_blocks;
    bit          m_sat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_bits = 0; m_blkerr = 0; m_acc = 0; m_max = 0; m_blocks = 0; m_sat = 0;
    endtask

    task automatic retire(input ent_t e);
        int unsigned sum;
        sum = m_acc + e.err;
        if (sum > ACC_MAX) sum = ACC_MAX;
        if (sum == ACC_MAX) m_sat = 1;
        m_bits = m_bits + e.err;
        if (m_bits > CNT_MAX) m_bits = CNT_MAX;
        if (m_bits == CNT_MAX) m_sat = 1;
        if (e.last) begin
            m_blocks++;
            if (sum > int'(err_threshold) && m_blkerr < CNT_MAX) m_blkerr++;
            if (m_blkerr == CNT_MAX) m_sat = 1;
            if (sum > m_max) m_max = sum;
            m_acc = 0;
        end else begin
            m_acc = sum;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!resetn || clear) begin
            sb.delete();
            model_zero();
            exp_ready = 0;
        end else begin
            exp_ready = 1;
            while (sb.size() > 0 && sb[0].due == cyc) retire(sb.pop_front());
        end
        chk("tready", 64'(tready), 64'(exp_ready));
        chk("bit_errors", 64'(bit_errors), 64'(m_bits));
        chk("block_errors", 64'(block_errors), 64'(m_blkerr));
        chk("blocks_done", blocks_done, m_blocks);
        chk("saturated", 64'(saturated), 64'(m_sat));
`ifdef LDPC_BER_MAX_ERR_EN
        chk("max_block_err", 64'(max_block_err), 64'(m_max));
`else
        chk("max_block_err", 64'(max_block_err), 64'd0);
`endif
    endtask

    // n distinct ones scattered across lanes (stride 13 is coprime with 128)
    function automatic logic [DW-1:0] sp(input int unsigned n);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[(i * 13) % DW] = 1'b1;
        return v;
    endfunction

    task automatic send(input logic [DW-1:0] d, input bit l);
        int   guard;
        bit   acc;
        ent_t e;
        logic [DW-1:0] m;
        guard = 0;
        tdata = d; tlast = l; tvalid = 1'b1;
        do begin
            acc = exp_ready && !clear;
            if (acc) begin
                m = l ? last_mask : {DW{1'b1}};
                e.due = cyc + 3; e.err = $countones(d & m); e.last = l;
                sb.push_back(e);
            end
            tick();
            guard++;
        end while (!acc && guard < 10);
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        repeat (n) tick();
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] m100;
        cyc = 0; n_tests = 0; n_fail = 0; exp_ready = 0;
        model_zero();
        resetn = 1'b0; clear = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        last_mask = '1; err_threshold = 16'd11;
        repeat (3) tick();
        resetn = 1'b1;

        // Clean stream: four 8-beat all-zero blocks
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++) send('0, i == 7);
        idle(4);
        chk("zero_blocks_done", blocks_done, 64'd4);
        chk("zero_bit_errors", 64'(bit_errors), 64'd0);

        // Threshold just below and at the block error count
        clr();
        err_threshold = 16'd11;
        send(sp(5), 0); send('0, 0); send(sp(7), 1);
        idle(4);
        chk("thr11_bits", 64'(bit_errors), 64'd12);
        chk("thr11_blkerr", 64'(block_errors), 64'd1);
        chk("thr11_blocks", blocks_done, 64'd1);
        clr();
        err_threshold = 16'd12;
        send(sp(5), 0); send('0, 0); send(sp(7), 1);
        idle(4);
        chk("thr12_blkerr", 64'(block_errors), 64'd0);
        err_threshold = 16'd11;

        // last_mask applies to the tlast beat only
        clr();
        m100 = '0;
        for (int i = 0; i < 100; i++) m100[i] = 1'b1;
        last_mask = m100;
        send('1, 1);
        idle(4);
        chk("mask_bits", 64'(bit_errors), 64'd100);
        last_mask = '1;

        // Clear mid-block with continuous tvalid
        clr();
        send(sp(4), 0); send(sp(6), 0);
        tdata = sp(2); tlast = 1'b0;
        clr();
        send(sp(2), 0); send(sp(1), 1);
        send(sp(1), 0); send(sp(1), 0); send('0, 0); send(sp(1), 1);
        idle(4);
        chk("midclr_blocks", blocks_done, 64'd2);
        chk("midclr_bits", 64'(bit_errors), 64'd6);

        // Saturation of the 8-bit bit counter
        clr();
        send('1, 1); send('1, 1); send('1, 1);
        idle(4);
        chk("sat_bits", 64'(bit_errors), 64'd255);
        chk("sat_flag", 64'(saturated), 64'd1);
        chk("sat_blocks", blocks_done, 64'd3);
        clr();
        chk("sat_cleared", 64'(saturated), 64'd0);

        // Max per-block error tracking
        send(sp(4), 1); send(sp(9), 1); send(sp(2), 1);
        idle(4);
`ifdef LDPC_BER_MAX_ERR_EN
        chk("max_err", 64'(max_block_err), 64'd9);
`else
        chk("max_err", 64'(max_block_err), 64'd0);
`endif
        chk("drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
